// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: exception bit
// positions carried with each fetch-queue entry, the default reset PC,
// and the fetch run/halt state.
package if_fetch_unit_pkg;

    localparam int unsigned IF_EXCP_MISAL  = 0;
    localparam int unsigned IF_EXCP_ACCESS = 1;
    localparam int unsigned IF_EXCP_W      = 2;

    localparam logic [63:0] IF_PC_START = 64'h8000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with asynchronous reset and a synchronous flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// The read port shows the head entry, or zero when empty.
module if_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && (!full || do_pop) && !flush_i;
    assign dout_o  = empty ? '0 : mem_q[rd_q];
    assign count_o = cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Next pointer and occupancy; flush wins over push and pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
            else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer, count and storage registers; storage is cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, pipelined memory requests with a
// reserved fetch-queue slot per request, in-order response matching through
// a PC FIFO, and redirect handling that drops stale in-flight responses.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     INST_W    = 32,
    parameter logic [XLEN-1:0] PC_START  = XLEN'(IF_PC_START),
    parameter int unsigned     FQ_DEPTH  = 4,
    parameter int unsigned     MAX_OUTST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 excp_jmp_ena,
    input  logic [XLEN-1:0]      excp_pc,
    input  logic                 bj_ena,
    input  logic [XLEN-1:0]      new_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INST_W-1:0]    imem_rsp_data,
    input  logic                 imem_rsp_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [XLEN-1:0]      inst_pc,
    output logic [INST_W-1:0]    inst,
    output logic [IF_EXCP_W-1:0] if_excp
);

    localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned EW = XLEN + INST_W + IF_EXCP_W;

    logic [XLEN-1:0]      pc_q, pc_d;
    logic [OW-1:0]        outst_q, outst_d, drop_q, drop_d;
    fetch_state_e         state_q, state_d;

    logic                 redirect, pc_misal, slot_free, outst_free;
    logic [XLEN-1:0]      target, fifo_pc;
    logic                 req_fire, rsp_fire, rsp_push, misal_push;
    logic                 fq_push, fq_pop;
    logic [EW-1:0]        fq_din, fq_dout;
    logic [CW-1:0]        fq_count;
    logic [OW-1:0]        pcq_count;
    logic [IF_EXCP_W-1:0] rsp_excp, misal_excp;

    assign redirect   = excp_jmp_ena | bj_ena;
    assign target     = excp_jmp_ena ? excp_pc : new_pc;
    assign pc_misal   = (pc_q[1:0] != 2'b00);
    assign slot_free  = (32'(fq_count) + 32'(outst_q)) < FQ_DEPTH;
    assign outst_free = 32'(outst_q) < MAX_OUTST;

    assign imem_req_valid = !rst && !redirect && (state_q == FETCH_RUN) &&
                            !pc_misal && outst_free && slot_free;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid;

    // A response is kept only when nothing is left to drop and no redirect
    // is flushing the queue in the same cycle.
    assign rsp_push   = rsp_fire && (drop_q == '0) && !redirect;
    assign misal_push = !redirect && (state_q == FETCH_RUN) && pc_misal &&
                        slot_free && !rsp_push;

    assign fq_push = rsp_push || misal_push;
    assign fq_pop  = inst_valid && inst_ready && !redirect;

    // Exception vectors for the two entry sources.
    always_comb begin
        rsp_excp                   = '0;
        misal_excp                 = '0;
        rsp_excp[IF_EXCP_ACCESS]   = imem_rsp_err;
        misal_excp[IF_EXCP_MISAL]  = 1'b1;
        fq_din = rsp_push ? {fifo_pc, imem_rsp_data, rsp_excp}
                          : {pc_q, {INST_W{1'b0}}, misal_excp};
    end

    // PC, in-flight count and stale-response drop count.
    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (redirect)      pc_d = target;
        else if (req_fire) pc_d = pc_q + XLEN'(4);
        if (req_fire && !rsp_fire)                     outst_d = outst_q + OW'(1);
        else if (!req_fire && rsp_fire && outst_q != '0) outst_d = outst_q - OW'(1);
        if (redirect)                        drop_d = outst_d;
        else if (rsp_fire && drop_q != '0)   drop_d = drop_q - OW'(1);
    end

    // Run/halt: halt after a misaligned entry or a kept access fault.
    always_comb begin
        state_d = state_q;
        if (redirect)                                   state_d = FETCH_RUN;
        else if (misal_push)                            state_d = FETCH_HALT;
        else if (rsp_push && imem_rsp_err)              state_d = FETCH_HALT;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= PC_START;
            outst_q <= '0;
            drop_q  <= '0;
            state_q <= FETCH_RUN;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            state_q <= state_d;
        end
    end

    if_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (fq_push),
        .din_i   (fq_din),
        .pop_i   (fq_pop),
        .dout_o  (fq_dout),
        .count_o (fq_count)
    );

    if_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTST)
    ) u_pc_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .din_i   (pc_q),
        .pop_i   (rsp_fire),
        .dout_o  (fifo_pc),
        .count_o (pcq_count)
    );

    assign inst_valid               = (fq_count != '0);
    assign {inst_pc, inst, if_excp} = fq_dout;

    a_rsp_has_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outst_q != '0));
    a_pc_fifo_tracks_outst: assert property (@(posedge clk) disable iff (rst)
        pcq_count == outst_q);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory responder, decode-side scoreboard
// derived from the sequential-PC rule, redirect table and directed corners.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int unsigned XLEN = 64, INST_W = 32, FQ_DEPTH = 4, MAX_OUTST = 2;
    localparam logic [63:0] PC0 = 64'h8000_0000;

    logic              clk = 1'b0, rst;
    logic              excp_jmp_ena, bj_ena;
    logic [XLEN-1:0]   excp_pc, new_pc;
    logic              imem_req_valid, imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid, imem_rsp_err;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid, inst_ready;
    logic [XLEN-1:0]   inst_pc;
    logic [INST_W-1:0] inst;
    logic [1:0]        if_excp;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN(XLEN), .INST_W(INST_W), .PC_START(PC0),
        .FQ_DEPTH(FQ_DEPTH), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .excp_jmp_ena(excp_jmp_ena), .excp_pc(excp_pc),
        .bj_ena(bj_ena), .new_pc(new_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_pc(inst_pc), .inst(inst), .if_excp(if_excp)
    );

    int unsigned vectors = 0, miscompares = 0;

    typedef struct { logic [63:0] addr; bit stale; } inflight_t;
    inflight_t mq[$];

    int unsigned p_ready, p_rsp, p_pop;
    logic [63:0] err_addr;
    logic [63:0] exp_req, exp_pop, first_req;
    bit          m_halt, m_stop, seen_pop;
    logic [63:0] last_pop_pc;
    logic [1:0]  last_pop_excp;
    int unsigned n_req, n_pop;

    typedef struct {
        bit exc; bit bj; logic [63:0] epc; logic [63:0] npc;
        logic [63:0] pc_exp; logic [1:0] excp_exp;
    } redir_vec_t;
    redir_vec_t tbl[5];

    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        excp_jmp_ena = 0; bj_ena = 0; excp_pc = '0; new_pc = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        imem_rsp_err = 0; inst_ready = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_req = PC0; exp_pop = PC0; m_halt = 0; m_stop = 0;
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later.
    task automatic cycle(input bit exc, input bit bj, input logic [63:0] epc, input logic [63:0] npc);
        bit rsp, rsp_stale, rsp_err, redir;
        logic [63:0] tgt;
        inflight_t h;
        @(negedge clk);
        excp_jmp_ena = exc; bj_ena = bj; excp_pc = epc; new_pc = npc;
        imem_req_ready = ($urandom_range(99) < p_ready);
        inst_ready     = ($urandom_range(99) < p_pop);
        rsp = (mq.size() > 0) && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rsp; imem_rsp_data = '0; imem_rsp_err = 0;
        rsp_stale = 1; rsp_err = 0;
        if (rsp) begin
            h = mq.pop_front();
            rsp_stale = h.stale;
            rsp_err = (h.addr == err_addr);
            imem_rsp_data = memword(h.addr);
            imem_rsp_err = rsp_err;
        end
        #1;
        redir = exc | bj;
        tgt = exc ? epc : npc;
        seen_pop = 0;
        if (!inst_valid) chk("empty_fields", {inst_pc, inst, if_excp}, '0);
        if (redir) begin
            chk("req_valid_in_redirect", imem_req_valid, 0);
            foreach (mq[i]) mq[i].stale = 1'b1;
            exp_req = tgt; exp_pop = tgt; m_halt = 0; m_stop = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                if (n_req == 0) first_req = imem_req_addr;
                n_req++;
                chk("req_addr", imem_req_addr, exp_req);
                chk("req_aligned", imem_req_addr[1:0], 0);
                chk("req_while_halted", m_halt, 0);
                exp_req += 4;
                mq.push_back('{addr: imem_req_addr, stale: 1'b0});
                chk("outstanding_limit", mq.size() <= MAX_OUTST, 1);
            end
            if (inst_valid && inst_ready) begin
                seen_pop = 1; n_pop++;
                last_pop_pc = inst_pc; last_pop_excp = if_excp;
                chk("pop_after_misaligned", m_stop, 0);
                chk("inst_pc", inst_pc, exp_pop);
                if (exp_pop[1:0] != 2'b00) begin
                    chk("inst_misal", inst, 0);
                    chk("if_excp_misal", if_excp, 2'b01);
                    m_stop = 1;
                end else begin
                    chk("inst", inst, memword(exp_pop));
                    chk("if_excp", if_excp, (exp_pop == err_addr) ? 2'b10 : 2'b00);
                end
                exp_pop += 4;
            end
            if (rsp && !rsp_stale && rsp_err) m_halt = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; idle_inputs(); model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic run_until_pop(input int unsigned max, output bit found);
        found = 0;
        for (int unsigned i = 0; i < max && !found; i++) begin
            cycle(0, 0, '0, '0);
            found = seen_pop;
        end
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        tbl[0] = '{1, 1, 64'h8000_0100, 64'h8000_2000, 64'h8000_0100, 2'b00};
        tbl[1] = '{0, 1, 64'h0,         64'h8000_0002, 64'h8000_0002, 2'b01};
        tbl[2] = '{1, 0, 64'h8000_0204, 64'h0,         64'h8000_0204, 2'b00};
        tbl[3] = '{0, 1, 64'h8000_0700, 64'h8000_0400, 64'h8000_0400, 2'b00};
        tbl[4] = '{1, 0, 64'h8000_0301, 64'h8000_0500, 64'h8000_0301, 2'b01};

        rst = 1; idle_inputs(); err_addr = '1; model_reset();
        p_ready = 100; p_rsp = 100; p_pop = 100; n_req = 0; n_pop = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_inst_valid", inst_valid, 0);
        chk("reset_fields", {inst_pc, inst, if_excp}, '0);
        rst = 0;

        // Full-rate streaming from reset.
        n_req = 0; n_pop = 0;
        repeat (10) cycle(0, 0, '0, '0);
        chk("stream_reqs", n_req, 10);
        chk("stream_pops", n_pop, 8);
        chk("stream_first_req", first_req, PC0);

        // Decode stalled: exactly FQ_DEPTH requests, then release.
        do_reset();
        p_pop = 0; n_req = 0;
        repeat (12) cycle(0, 0, '0, '0);
        chk("full_reqs", n_req, FQ_DEPTH);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_inst_valid", inst_valid, 1);
        p_pop = 100; n_req = 0; n_pop = 0;
        repeat (12) cycle(0, 0, '0, '0);
        chk("drain_pops", n_pop >= FQ_DEPTH, 1);
        chk("drain_resumed", n_req > 0, 1);

        // Branch with two requests in flight and a non-empty queue.
        do_reset();
        p_pop = 0; p_rsp = 100;
        repeat (3) cycle(0, 0, '0, '0);
        p_rsp = 0;
        repeat (2) cycle(0, 0, '0, '0);
        chk("br_inflight", mq.size(), 2);
        chk("br_req_blocked", imem_req_valid, 0);
        chk("br_queue_nonempty", inst_valid, 1);
        cycle(0, 1, '0, 64'h8000_1000);
        cycle(0, 0, '0, '0);
        chk("br_queue_flushed", inst_valid, 0);
        p_rsp = 100; p_pop = 100;
        run_until_pop(20, found);
        chk("br_found", found, 1);
        chk("br_first_pc", last_pop_pc, 64'h8000_1000);

        // Redirect table.
        foreach (tbl[k]) begin
            p_ready = 100; p_rsp = 100; p_pop = 100;
            repeat (3) cycle(0, 0, '0, '0);
            cycle(tbl[k].exc, tbl[k].bj, tbl[k].epc, tbl[k].npc);
            run_until_pop(40, found);
            chk("tbl_found", found, 1);
            chk("tbl_pc", last_pop_pc, tbl[k].pc_exp);
            chk("tbl_excp", last_pop_excp, tbl[k].excp_exp);
            if (tbl[k].excp_exp[0]) begin
                n_req = 0;
                repeat (8) cycle(0, 0, '0, '0);
                chk("tbl_halt_no_req", n_req, 0);
                chk("tbl_halt_empty", inst_valid, 0);
            end
        end

        // Access fault halts fetch.
        do_reset();
        err_addr = PC0 + 64'h8;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 0, '0, '0);
            if (seen_pop && last_pop_excp == 2'b10) found = 1;
        end
        chk("fault_found", found, 1);
        chk("fault_pc", last_pop_pc, PC0 + 64'h8);
        n_req = 0;
        repeat (8) cycle(0, 0, '0, '0);
        chk("fault_no_req", n_req, 0);
        chk("fault_req_valid", imem_req_valid, 0);

        // Asynchronous reset in the middle of a burst.
        err_addr = '1;
        cycle(0, 1, '0, PC0 + 64'h40);
        p_pop = 50;
        repeat (5) cycle(0, 0, '0, '0);
        @(negedge clk);
        #2 rst = 1; idle_inputs();
        #1;
        chk("async_req_valid", imem_req_valid, 0);
        chk("async_inst_valid", inst_valid, 0);
        chk("async_fields", {inst_pc, inst, if_excp}, '0);
        model_reset();
        @(negedge clk);
        rst = 0;
        p_pop = 100; n_req = 0;
        repeat (4) cycle(0, 0, '0, '0);
        chk("restart_reqs", n_req > 0, 1);
        chk("restart_pc", first_req, PC0);

        // Randomized traffic and redirects.
        do_reset();
        for (int unsigned c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                p_ready = $urandom_range(100, 20);
                p_rsp   = $urandom_range(100, 20);
                p_pop   = $urandom_range(100, 20);
            end
            if ($urandom_range(99) < 3) begin
                logic [63:0] t;
                t = PC0 + 64'($urandom_range(1023, 0)) * 4;
                if ($urandom_range(7) == 0) t = t + 2;
                if ($urandom_range(3) == 0) err_addr = t + 64'($urandom_range(8, 0)) * 4;
                else err_addr = '1;
                if ($urandom_range(1) == 0) cycle(1, $urandom_range(1), t, t ^ 64'h100);
                else cycle(0, 1, t ^ 64'h100, t);
            end else begin
                cycle(0, 0, '0, '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
